// File: rtl/alu_op_sequencer.sv
// Command-driven controller for the shift + ALU datapath: captures one command,
// iterates it through the combinational datapath with result feedback, then holds the response.
module alu_op_sequencer #(
    parameter int W      = 5,
    parameter int ITER_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W-1:0]      cmd_a,
    input  logic [W-1:0]      cmd_b,
    input  logic [2:0]        cmd_alu_ctrl,
    input  logic [1:0]        cmd_bshift,
    input  logic              cmd_dir,
    input  logic [ITER_W-1:0] cmd_iter,
    input  logic              abort,
    output logic [W-1:0]      dp_a,
    output logic [W-1:0]      dp_b,
    output logic [2:0]        dp_alu_ctrl,
    output logic [1:0]        dp_bshift,
    output logic              dp_select,
    input  logic [W-1:0]      dp_result,
    input  logic [3:0]        dp_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_sticky_cv,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      acc_q, acc_d;
    logic [W-1:0]      dp_a_q, dp_a_d;
    logic [W-1:0]      dp_b_q, dp_b_d;
    logic [2:0]        alu_ctrl_q, alu_ctrl_d;
    logic [1:0]        bshift_q, bshift_d;
    logic              select_q, select_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [3:0]        flags_q, flags_d;
    logic              sticky_q, sticky_d;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        dp_a_d     = dp_a_q;
        dp_b_d     = dp_b_q;
        alu_ctrl_d = alu_ctrl_q;
        bshift_d   = bshift_q;
        select_d   = select_q;
        cnt_d      = cnt_q;
        flags_d    = flags_q;
        sticky_d   = sticky_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    acc_d      = cmd_a;
                    dp_a_d     = cmd_a;
                    dp_b_d     = cmd_b;
                    alu_ctrl_d = cmd_alu_ctrl;
                    bshift_d   = cmd_bshift;
                    select_d   = cmd_dir;
                    cnt_d      = (cmd_iter == '0) ? ITER_W'(1) : cmd_iter;
                    sticky_d   = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = dp_result;
                    flags_d  = dp_flags;
                    sticky_d = sticky_q | dp_flags[1] | dp_flags[0];
                    cnt_d    = cnt_q - ITER_W'(1);
                    // The operand only advances while more iterations remain, so the
                    // datapath inputs stay frozen on the last operand once DONE is reached.
                    if (cnt_q == ITER_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        dp_a_d = dp_result;
                    end
                end
            end
            DONE: begin
                if (rsp_ready || abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            alu_ctrl_q <= '0;
            bshift_q   <= '0;
            select_q   <= 1'b0;
            cnt_q      <= '0;
            flags_q    <= '0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            dp_a_q     <= dp_a_d;
            dp_b_q     <= dp_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            bshift_q   <= bshift_d;
            select_q   <= select_d;
            cnt_q      <= cnt_d;
            flags_q    <= flags_d;
            sticky_q   <= sticky_d;
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign rsp_valid     = (state_q == DONE);
    assign rsp_result    = acc_q;
    assign rsp_flags     = flags_q;
    assign rsp_sticky_cv = sticky_q;
    assign dp_a          = dp_a_q;
    assign dp_b          = dp_b_q;
    assign dp_alu_ctrl   = alu_ctrl_q;
    assign dp_bshift     = bshift_q;
    assign dp_select     = select_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural shift+add datapath stub.
module tb_alu_op_sequencer;

    localparam int W      = 5;
    localparam int ITER_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [W-1:0]      cmd_a;
    logic [W-1:0]      cmd_b;
    logic [2:0]        cmd_alu_ctrl;
    logic [1:0]        cmd_bshift;
    logic              cmd_dir;
    logic [ITER_W-1:0] cmd_iter;
    logic              abort;
    logic [W-1:0]      dp_a;
    logic [W-1:0]      dp_b;
    logic [2:0]        dp_alu_ctrl;
    logic [1:0]        dp_bshift;
    logic              dp_select;
    logic [W-1:0]      dp_result;
    logic [3:0]        dp_flags;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_sticky_cv;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         stk;
        int           n;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.W(W), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_alu_ctrl(cmd_alu_ctrl),
        .cmd_bshift(cmd_bshift), .cmd_dir(cmd_dir), .cmd_iter(cmd_iter),
        .abort(abort),
        .dp_a(dp_a), .dp_b(dp_b), .dp_alu_ctrl(dp_alu_ctrl),
        .dp_bshift(dp_bshift), .dp_select(dp_select),
        .dp_result(dp_result), .dp_flags(dp_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_sticky_cv(rsp_sticky_cv), .busy(busy)
    );

    // Datapath stub: shift then add, flags {N, Z, C, V=0}
    logic [W-1:0] stub_sh;
    logic [W:0]   stub_sum;
    always_comb begin
        stub_sh   = dp_select ? (dp_a >> dp_bshift) : (dp_a << dp_bshift);
        stub_sum  = {1'b0, stub_sh} + {1'b0, dp_b};
        dp_result = stub_sum[W-1:0];
        dp_flags  = {stub_sum[W-1], (stub_sum[W-1:0] == '0), stub_sum[W], 1'b0};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_step(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [1:0] bs, input logic dir,
                                     output logic [W-1:0] r, output logic [3:0] f);
        logic [W-1:0] s;
        int           t;
        s = dir ? (a >> bs) : (a << bs);
        t = int'(s) + int'(b);
        r = W'(t % 32);
        f = {r[W-1], (r == '0), (t >= 32), 1'b0};
    endfunction

    task automatic send_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] bs, input logic dir, input logic [ITER_W-1:0] it);
        exp_t         e;
        logic [W-1:0] acc;
        logic [3:0]   f;
        bit           accepted = 0;
        e.n   = (it == 0) ? 1 : int'(it);
        e.stk = 1'b0;
        acc   = a;
        f     = '0;
        for (int i = 0; i < e.n; i++) begin
            ref_step(acc, b, bs, dir, acc, f);
            e.stk = e.stk | f[1] | f[0];
        end
        e.res = acc;
        e.flg = f;
        sb.push_back(e);
        cmd_a = a; cmd_b = b; cmd_alu_ctrl = 3'd2; cmd_bshift = bs;
        cmd_dir = dir; cmd_iter = it; cmd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (cmd_ready) begin
                @(posedge clk);
                accepted = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!accepted) check("cmd_accept_timeout", 0, 1);
        #1 cmd_valid = 1'b0;
    endtask

    // Called #1 after the accepting edge; hold = cycles of backpressure with a competing command
    task automatic get_rsp(input int hold);
        exp_t e;
        int   cyc = 0;
        e = sb.pop_front();
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, e.n);
        check("rsp_result", rsp_result, e.res);
        check("rsp_flags", rsp_flags, e.flg);
        check("rsp_sticky", rsp_sticky_cv, e.stk);
        if (hold > 0) begin
            cmd_a = 5'd9; cmd_iter = 3'd2; cmd_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("bp_valid", rsp_valid, 1);
                check("bp_result", rsp_result, e.res);
                check("bp_flags", rsp_flags, e.flg);
                check("bp_cmd_ready", cmd_ready, 0);
            end
            cmd_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
        check("post_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_alu_ctrl = '0;
        cmd_bshift = '0; cmd_dir = 1'b0; cmd_iter = '0; abort = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_outs", {dp_a, dp_b, dp_alu_ctrl, dp_bshift, dp_select, rsp_result, rsp_flags, rsp_sticky_cv}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op
        send_cmd(5'd3, 5'd1, 2'd1, 1'b0, 3'd1);
        check("single_dp_a", dp_a, 3);
        check("single_busy", busy, 1);
        get_rsp(0);

        // Iterative 3 -> 7 -> 15, checking operand feedback
        send_cmd(5'd1, 5'd1, 2'd1, 1'b0, 3'd3);
        check("iter_dp_a0", dp_a, 1);
        check("iter_dp_b", dp_b, 1);
        @(posedge clk); #1;
        check("iter_dp_a1", dp_a, 3);
        sb[0].n = sb[0].n - 1;
        get_rsp(0);

        // iter=0 behaves as one iteration
        send_cmd(5'd1, 5'd1, 2'd1, 1'b0, 3'd0);
        get_rsp(0);

        // Right shift, several iterations
        send_cmd(5'd30, 5'd5, 2'd2, 1'b1, 3'd5);
        get_rsp(0);

        // Wrap: 16+16 -> 0 with Z and C
        send_cmd(5'd16, 5'd16, 2'd0, 1'b0, 3'd1);
        get_rsp(0);

        // Max iterations with sticky carry
        send_cmd(5'd7, 5'd9, 2'd3, 1'b0, 3'd7);
        get_rsp(0);

        // Backpressure with a competing command held on the input
        send_cmd(5'd2, 5'd3, 2'd1, 1'b0, 3'd2);
        get_rsp(5);

        // Abort in EXEC cycle 2
        send_cmd(5'd1, 5'd1, 2'd1, 1'b0, 3'd7);
        void'(sb.pop_back());
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        check("abort_no_rsp", seen, 0);

        // Asynchronous reset mid-EXEC
        send_cmd(5'd5, 5'd3, 2'd1, 1'b0, 3'd7);
        void'(sb.pop_back());
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_outs", {dp_a, dp_b, dp_alu_ctrl, dp_bshift, dp_select, rsp_result, rsp_flags, rsp_sticky_cv}, 0);
        #3 rst_n = 1'b1;
        send_cmd(5'd4, 5'd2, 2'd1, 1'b0, 3'd2);
        get_rsp(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
